// File: rtl/rom_ctrl_pkg.sv
// Shared types and sizing helpers for the ROM scan engine.
package rom_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } rom_scan_state_e;

  // Bits needed to hold values 0..value-1 (at least one bit).
  function automatic int vbits(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  // Two spare entries on top of the read latency keep one word per cycle flowing.
  function automatic int buf_depth(input int read_latency);
    return read_latency + 2;
  endfunction

endpackage

// File: rtl/rom_ctrl_scan_fifo.sv
// Small {data, addr} buffer for returned ROM words; synchronous clear, no pass-through.
module rom_ctrl_scan_fifo
  import rom_ctrl_pkg::*;
#(
  parameter int Depth = 3,
  parameter int Width = 44
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o
);

  localparam int PW = vbits(Depth);
  localparam int CW = vbits(Depth + 1);
  localparam logic [PW-1:0] LastPtr = PW'(Depth - 1);
  localparam logic [CW-1:0] FullCnt = CW'(Depth);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             do_push, do_pop, full;

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == FullCnt);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PW'(1);
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: nothing reads it while the count is zero.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rom_ctrl_scan_counter.sv
// ROM scan engine: issues sequential reads, tracks in-flight data and streams words to the checker.
//   state   | meaning
//   StIdle  | waiting for start_i
//   StScan  | issuing reads 0..TopAddr under the credit limit
//   StDrain | all reads issued, waiting for the TopAddr word to be accepted
//   StDone  | scan complete, waiting for start_i
module rom_ctrl_scan_counter
  import rom_ctrl_pkg::*;
#(
  parameter int RomDepth    = 16,
  parameter int RomTopCount = 2,
  parameter int DataWidth   = 40,
  parameter int ReadLatency = 1,
  parameter int AutoStart   = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic                        abort_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        read_req_o,
  output logic [vbits(RomDepth)-1:0]  read_addr_o,
  input  logic [DataWidth-1:0]        rom_rdata_i,
  output logic                        data_vld_o,
  input  logic                        data_rdy_i,
  output logic [DataWidth-1:0]        data_o,
  output logic [vbits(RomDepth)-1:0]  data_addr_o,
  output logic                        data_last_nontop_o,
  output logic                        data_top_o
);

  localparam int AW       = vbits(RomDepth);
  localparam int BufDepth = buf_depth(ReadLatency);
  localparam int CW       = vbits(BufDepth + 1);
  localparam int FW       = DataWidth + AW;
  localparam logic [AW-1:0] TopAddr     = AW'(RomDepth - 1);
  localparam logic [AW-1:0] LastNonTop  = AW'(RomDepth - RomTopCount - 1);
  localparam logic [AW-1:0] FirstTop    = AW'(RomDepth - RomTopCount);
  localparam logic [CW-1:0] CreditLimit = CW'(BufDepth);
  localparam rom_scan_state_e ResetState = (AutoStart != 0) ? StScan : StIdle;

  rom_scan_state_e        state_q, state_d;
  logic [AW-1:0]          issue_q, issue_d;
  logic [CW-1:0]          credit_q, credit_d;
  logic [ReadLatency-1:0] sr_vld_q, sr_vld_d;
  logic [AW-1:0]          sr_addr_q [ReadLatency];
  logic [AW-1:0]          sr_addr_d [ReadLatency];

  logic          issue, pop, fifo_empty, head_vld;
  logic [FW-1:0] head;
  logic [AW-1:0] head_addr;

  assign issue     = (state_q == StScan) && (credit_q < CreditLimit);
  assign head_vld  = !fifo_empty;
  assign pop       = head_vld && data_rdy_i;
  assign head_addr = head[AW-1:0];

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StScan;
          issue_d = '0;
        end
      end
      StScan: begin
        if (issue) begin
          if (issue_q == TopAddr) state_d = StDrain;
          else                    issue_d = issue_q + AW'(1);
        end
      end
      StDrain: begin
        if (pop && (head_addr == TopAddr)) state_d = StDone;
      end
      StDone: begin
        if (start_i) begin
          state_d = StScan;
          issue_d = '0;
        end
      end
      default: state_d = ResetState;
    endcase
    if (abort_i) state_d = StIdle;
  end

  always_comb begin
    credit_d = credit_q;
    if (issue && !pop)      credit_d = credit_q + CW'(1);
    else if (!issue && pop) credit_d = credit_q - CW'(1);
    if (abort_i) credit_d = '0;
  end

  // Stage ReadLatency-1 lines up with the cycle the ROM presents the data.
  always_comb begin
    sr_vld_d     = sr_vld_q;
    sr_addr_d    = sr_addr_q;
    sr_vld_d[0]  = issue;
    sr_addr_d[0] = issue_q;
    for (int i = 1; i < ReadLatency; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_addr_d[i] = sr_addr_q[i-1];
    end
    if (abort_i) sr_vld_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ResetState;
      issue_q  <= '0;
      credit_q <= '0;
      sr_vld_q <= '0;
      for (int i = 0; i < ReadLatency; i++) sr_addr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      credit_q  <= credit_d;
      sr_vld_q  <= sr_vld_d;
      sr_addr_q <= sr_addr_d;
    end
  end

  rom_ctrl_scan_fifo #(
    .Depth (BufDepth),
    .Width (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (abort_i),
    .push_i  (sr_vld_q[ReadLatency-1]),
    .wdata_i ({rom_rdata_i, sr_addr_q[ReadLatency-1]}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty)
  );

  assign busy_o             = (state_q == StScan) || (state_q == StDrain);
  assign done_o             = (state_q == StDone);
  assign read_req_o         = issue;
  assign read_addr_o        = issue_q;
  assign data_vld_o         = head_vld;
  assign data_o             = head_vld ? head[FW-1:AW] : '0;
  assign data_addr_o        = head_vld ? head_addr : '0;
  assign data_last_nontop_o = head_vld && (head_addr == LastNonTop);
  assign data_top_o         = head_vld && (head_addr >= FirstTop);

endmodule

// File: tb/tb_rom_ctrl_scan_counter.sv
// Scoreboard bench for rom_ctrl_scan_counter (RomDepth=16, RomTopCount=2, ReadLatency=3, AutoStart=1).
module tb_rom_ctrl_scan_counter;

  localparam int DEPTH = 16;
  localparam int DW    = 40;
  localparam int LAT   = 3;
  localparam int AW    = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          top;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rdy = 1'b1;
  logic          busy_o, done_o, read_req_o, data_vld_o;
  logic          data_last_nontop_o, data_top_o;
  logic [AW-1:0] read_addr_o, data_addr_o;
  logic [DW-1:0] data_o;
  logic [DW-1:0] rom_rdata = '0;

  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   t = 0;
  int   scan0 = 0;

  always #5 clk = ~clk;

  rom_ctrl_scan_counter #(
    .RomDepth    (DEPTH),
    .RomTopCount (2),
    .DataWidth   (DW),
    .ReadLatency (LAT),
    .AutoStart   (1)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .start_i            (start),
    .abort_i            (abort),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .read_req_o         (read_req_o),
    .read_addr_o        (read_addr_o),
    .rom_rdata_i        (rom_rdata),
    .data_vld_o         (data_vld_o),
    .data_rdy_i         (rdy),
    .data_o             (data_o),
    .data_addr_o        (data_addr_o),
    .data_last_nontop_o (data_last_nontop_o),
    .data_top_o         (data_top_o)
  );

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return {4'hA, a, 8'h3C, a, 16'hBEEF, a};
  endfunction

  // ROM model: data for a request seen in cycle c is driven during cycle c+LAT.
  logic [AW:0] rom_pipe [LAT+1] = '{default: '0};
  always @(negedge clk) begin
    for (int k = LAT; k > 0; k--) rom_pipe[k] = rom_pipe[k-1];
    rom_pipe[0] = {read_req_o, read_addr_o};
    rom_rdata = rom_pipe[LAT][AW] ? rom_word(rom_pipe[LAT][AW-1:0]) : 40'hDE_AD00_DEAD;
  end

  // Monitor: every accepted word is checked against the head of the expected queue.
  logic          hold_pending = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  always @(negedge clk) begin
    exp_t e, got;
    if (rst_n && hold_pending) begin
      compared++;
      if (!(data_vld_o && data_addr_o == hold_addr && data_o == hold_data)) begin
        mismatched++;
        $display("FAIL hold: got vld=%b addr=%0d data=%h, required vld=1 addr=%0d data=%h",
                 data_vld_o, data_addr_o, data_o, hold_addr, hold_data);
      end
    end
    if (rst_n && data_vld_o && rdy) begin
      got.addr = data_addr_o;
      got.data = data_o;
      got.last = data_last_nontop_o;
      got.top  = data_top_o;
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_word: got addr=%0d data=%h, required no word", got.addr, got.data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          mismatched++;
          $display("FAIL word: got addr=%0d data=%h last=%b top=%b, required addr=%0d data=%h last=%b top=%b",
                   got.addr, got.data, got.last, got.top, e.addr, e.data, e.last, e.top);
        end
      end
    end
    hold_pending = rst_n && data_vld_o && !rdy && !abort;
    hold_addr    = data_addr_o;
    hold_data    = data_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_scan();
    for (int a = 0; a < DEPTH; a++) begin
      exp_t e;
      e.addr = AW'(a);
      e.data = rom_word(AW'(a));
      e.last = (a == 13);
      e.top  = (a >= 14);
      exp_q.push_back(e);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_req"}, read_req_o, 1);
    chk({tag, "_raddr"}, read_addr_o, 0);
    chk({tag, "_vld"}, data_vld_o, 0);
    chk({tag, "_data"}, data_o, 0);
    chk({tag, "_daddr"}, data_addr_o, 0);
    chk({tag, "_last"}, data_last_nontop_o, 0);
    chk({tag, "_top"}, data_top_o, 0);
  endtask

  task automatic wait_done(input string name, input int req_cycle);
    int n = 0;
    while (!done_o && n < 200) begin
      step();
      n++;
    end
    if (!done_o) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: done_o=0 after %0d cycles, required 1", name, n);
    end else begin
      chk(name, t - scan0, req_cycle);
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic start_scan();
    start = 1'b1;
    step();
    start = 1'b0;
    scan0 = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    t = 0;
    scan0 = 0;

    // Streaming straight out of reset.
    push_scan();
    chk("c0_req", read_req_o, 1);
    chk("c0_addr", read_addr_o, 0);
    n = 0;
    while (!data_vld_o && n < 50) begin
      step();
      n++;
    end
    chk("first_vld_cycle", t - scan0, 4);
    wait_done("stream_done", 20);

    // Restart from Done; start_i mid-scan must be ignored.
    chk("done_high", done_o, 1);
    start_scan();
    push_scan();
    chk("restart_done", done_o, 0);
    chk("restart_req", read_req_o, 1);
    chk("restart_addr", read_addr_o, 0);
    repeat (3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ignored_start_addr", read_addr_o, 4);
    wait_done("restart_done", 20);

    // Backpressure: consumer stalls cycles 4..13.
    start_scan();
    push_scan();
    repeat (4) step();
    rdy = 1'b0;
    chk("bp_c4_req", read_req_o, 1);
    chk("bp_c4_addr", read_addr_o, 4);
    repeat (4) step();
    chk("bp_c8_req", read_req_o, 0);
    chk("bp_c8_addr", read_addr_o, 5);
    chk("bp_c8_vld", data_vld_o, 1);
    chk("bp_c8_daddr", data_addr_o, 0);
    repeat (6) step();
    rdy = 1'b1;
    wait_done("bp_done", 30);

    // Abort in cycle 6, late data must be dropped, then a clean rescan from Idle.
    start_scan();
    push_scan();
    repeat (6) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_vld", data_vld_o, 0);
    chk("abort_req", read_req_o, 0);
    chk("abort_done", done_o, 0);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_quiet_vld", data_vld_o, 0);
    end
    start_scan();
    push_scan();
    chk("rescan_req", read_req_o, 1);
    chk("rescan_addr", read_addr_o, 0);
    wait_done("rescan_done", 20);

    // abort_i with start_i in Done goes to Idle.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abst_done", done_o, 0);
    chk("abst_busy", busy_o, 0);
    chk("abst_req", read_req_o, 0);
    step();
    chk("abst_stay_idle", busy_o, 0);

    // Reset during Drain, then the scan restarts on its own.
    start_scan();
    push_scan();
    repeat (17) step();
    chk("drain_busy", busy_o, 1);
    chk("drain_req", read_req_o, 0);
    rst_n = 1'b0;
    step();
    chk_reset_vals("midrst");
    exp_q.delete();
    rst_n = 1'b1;
    scan0 = t;
    push_scan();
    wait_done("post_rst_done", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
